// File: rtl/sel_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin select-code arbiter.
// Imported by the interface, the priority picker and the top level.
package sel_rr_arbiter_pkg;

  localparam int unsigned SelW            = 2;
  localparam int unsigned NumReq          = 4;
  localparam int unsigned CntW            = 4;
  localparam int unsigned DefaultMaxBeats = 4;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

  // One-hot grant vector for a select code.
  function automatic logic [NumReq-1:0] sel_to_gnt(input logic [SelW-1:0] sel);
    logic [NumReq-1:0] gnt;
    gnt      = '0;
    gnt[sel] = 1'b1;
    return gnt;
  endfunction

endpackage

// File: rtl/sel_rr_arbiter_if.sv
// Request/grant bundle between the requesters, the arbiter and the selector consumer.
// The arbiter drives sel/gnt/valid; the environment drives req/ack.
interface sel_rr_arbiter_if;
  import sel_rr_arbiter_pkg::*;

  logic [NumReq-1:0] req;
  logic              ack;
  logic [SelW-1:0]   sel;
  logic [NumReq-1:0] gnt;
  logic              valid;

  modport master (
    input  req,
    input  ack,
    output sel,
    output gnt,
    output valid
  );

  modport slave (
    output req,
    output ack,
    input  sel,
    input  gnt,
    input  valid
  );

endinterface

// File: rtl/sel_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping,
// with last_i itself checked last.
module rr_pick
  import sel_rr_arbiter_pkg::*;
(
  input  logic [NumReq-1:0] req_i,
  input  logic [SelW-1:0]   last_i,
  output logic [SelW-1:0]   idx_o,
  output logic              found_o
);

  logic [SelW-1:0] cand;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    // Offset 4 wraps to last_i, giving it the lowest priority.
    for (int unsigned k = 1; k <= NumReq; k++) begin
      cand = last_i + SelW'(k);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/sel_rr_arbiter.sv
// Round-robin arbiter producing a registered 2-bit select code, one-hot grant and valid
// for a 4-to-1 selector; each grant lasts up to MaxBeats acknowledged beats.
module sel_rr_arbiter
  import sel_rr_arbiter_pkg::*;
#(
  parameter int unsigned MaxBeats = DefaultMaxBeats
) (
  input  logic              clk,
  input  logic              rst,
  sel_rr_arbiter_if.master  arb_if
);

  localparam logic [CntW-1:0] MaxBeatsW = CntW'(MaxBeats);

  state_e            state_q, state_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic [SelW-1:0]   last_q, last_d;
  logic [NumReq-1:0] gnt_q, gnt_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              valid_q, valid_d;

  logic [SelW-1:0]   pick_idx;
  logic              pick_found;
  logic [CntW-1:0]   cnt_inc;
  logic              beats_done;
  logic              owner_drop;

  rr_pick u_rr_pick (
    .req_i   (arb_if.req),
    .last_i  (last_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign cnt_inc    = cnt_q + 4'd1;
  assign beats_done = arb_if.ack && (cnt_inc == MaxBeatsW);
  assign owner_drop = !arb_if.req[sel_q];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;

    unique case (state_q)
      StIdle: begin
        // ack is ignored here: nothing is being presented downstream.
        if (pick_found) begin
          state_d = StGrant;
          sel_d   = pick_idx;
          gnt_d   = sel_to_gnt(pick_idx);
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      StGrant: begin
        if (arb_if.ack) begin
          cnt_d = cnt_inc;
        end
        // A dropped request with a same-cycle ack still counts that beat.
        if (beats_done || owner_drop) begin
          state_d = StIdle;
          last_d  = sel_q;
          gnt_d   = '0;
          valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      last_q  <= 2'b11;
      gnt_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign arb_if.sel   = sel_q;
  assign arb_if.gnt   = gnt_q;
  assign arb_if.valid = valid_q;

endmodule

// File: tb/tb_sel_rr_arbiter.sv
// Scoreboard bench: two arbiters (MaxBeats 4 and 1) share stimulus; a reference model
// queues expected {valid, sel, gnt} per cycle and a monitor compares after each edge.
module tb_sel_rr_arbiter;
  import sel_rr_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sel_rr_arbiter_if if_a ();
  sel_rr_arbiter_if if_b ();

  sel_rr_arbiter #(.MaxBeats(4)) u_dut4 (
    .clk    (clk),
    .rst    (rst),
    .arb_if (if_a)
  );

  sel_rr_arbiter #(.MaxBeats(1)) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .arb_if (if_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0] exp_a[$];
  logic [6:0] exp_b[$];

  // Model state per DUT: current owner (-1 when none), beats taken, last winner, held sel.
  int owner[2];
  int beats[2];
  int last[2];
  int sel_m[2];
  int max_b[2] = '{4, 1};

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got valid/sel/gnt=%b/%b/%b expected %b/%b/%b at %0t", name,
                  act[6], act[5:4], act[3:0], exp[6], exp[5:4], exp[3:0], $time);
  endtask

  task automatic mreset(input int d);
    owner[d] = -1;
    beats[d] = 0;
    last[d]  = 3;
    sel_m[d] = 0;
  endtask

  task automatic mstep(input int d, input logic [3:0] r, input logic a,
                       output logic [6:0] e);
    if (owner[d] < 0) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (last[d] + k) % 4;
        if (r[c]) begin
          owner[d] = c;
          beats[d] = 0;
          sel_m[d] = c;
          break;
        end
      end
    end else begin
      if (a) beats[d]++;
      if ((a && beats[d] == max_b[d]) || !r[owner[d]]) begin
        last[d]  = owner[d];
        owner[d] = -1;
      end
    end
    if (owner[d] >= 0) e = {1'b1, 2'(sel_m[d]), 4'(1 << sel_m[d])};
    else               e = {1'b0, 2'(sel_m[d]), 4'b0000};
  endtask

  // One cycle of stimulus applied at the falling edge.
  task automatic cyc(input logic [3:0] r, input logic a, input logic rs);
    logic [6:0] e;
    @(negedge clk);
    if_a.req = r;
    if_b.req = r;
    if_a.ack = a;
    if_b.ack = a;
    if (rs) begin
      rst = 1'b1;
      mreset(0);
      mreset(1);
      #1;
      check("dut4_async_reset", {if_a.valid, if_a.sel, if_a.gnt}, 7'b0);
      check("dut1_async_reset", {if_b.valid, if_b.sel, if_b.gnt}, 7'b0);
      exp_a.push_back(7'b0);
      exp_b.push_back(7'b0);
    end else begin
      rst = 1'b0;
      mstep(0, r, a, e);
      exp_a.push_back(e);
      mstep(1, r, a, e);
      exp_b.push_back(e);
    end
  endtask

  initial begin
    logic [6:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        check("dut4_out", {if_a.valid, if_a.sel, if_a.gnt}, e);
      end
      if (exp_b.size() > 0) begin
        e = exp_b.pop_front();
        check("dut1_out", {if_b.valid, if_b.sel, if_b.gnt}, e);
      end
    end
  end

  initial begin
    logic [3:0] r;
    int hold;
    if_a.req = '0;
    if_b.req = '0;
    if_a.ack = 1'b0;
    if_b.ack = 1'b0;
    mreset(0);
    mreset(1);

    repeat (2) cyc(4'b0000, 1'b0, 1'b1);
    repeat (12) cyc(4'b0100, 1'b1, 1'b0);
    repeat (26) cyc(4'b1111, 1'b1, 1'b0);

    // Owner drops its request after two beats; next winner follows index 1.
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0010, 1'b0, 1'b0);
    repeat (2) cyc(4'b0010, 1'b1, 1'b0);
    cyc(4'b1001, 1'b0, 1'b0);
    repeat (4) cyc(4'b1011, 1'b1, 1'b0);

    // Stray acks while idle must not disturb the next grant.
    repeat (3) cyc(4'b0000, 1'b0, 1'b0);
    repeat (3) cyc(4'b0000, 1'b1, 1'b0);
    repeat (7) cyc(4'b0100, 1'b1, 1'b0);

    // Reset in the middle of a grant.
    cyc(4'b0000, 1'b0, 1'b1);
    cyc(4'b0100, 1'b0, 1'b0);
    repeat (2) cyc(4'b0100, 1'b1, 1'b0);
    cyc(4'b0100, 1'b1, 1'b1);
    repeat (6) cyc(4'b1111, 1'b1, 1'b0);

    for (int i = 0; i < 10; i++) cyc(4'b0011, 1'(i % 2 == 0), 1'b0);

    r    = 4'b0000;
    hold = 0;
    for (int i = 0; i < 500; i++) begin
      if (hold == 0) begin
        r    = 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 9);
      end
      hold--;
      cyc(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
    end

    repeat (3) cyc(4'b0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sel_rr_arbiter.md
# sel_rr_arbiter

Round-robin arbiter that generates the 2-bit select code for the downstream 4-to-1 2-bit selector. It samples four request lines and grants one requester at a time. The grant is held for up to MAX_BEATS accepted beats, and the encoded index is driven on SEL with a VALID qualifier. The downstream stage consumes SEL directly, and the consumer of the selector output returns ACK per accepted beat.

## Interface
Parameters:
- MAX_BEATS, 4: maximum ACKed beats per grant before forced release; legal range 1..15.

Ports:
- CLK, input, 1: single clock; all state updates on rising edge.
- RST, input, 1: reset, asynchronous, active-high.
- REQ, input, 4: request per source; bit i maps to SEL = i (0→A, 1→B, 2→C, 3→D).
- ACK, input, 1: downstream accepted the current beat; meaningful only while VALID = 1.
- SEL, output, 2: registered select code to the 4-to-1 selector.
- GNT, output, 4: registered one-hot grant; equals decode of SEL while VALID = 1, else 0.
- VALID, output, 1: registered; SEL/GNT carry a live grant.

## Operation
- States: IDLE, GRANT.
- Pointer LAST[1:0] holds the last granted index. Priority order is LAST+1, LAST+2, LAST+3, LAST, all modulo 4.
- Beat counter CNT is 4 bits wide, counts ACKed beats in the current grant, and is cleared on entry to GRANT.
- IDLE:
  - If REQ ≠ 0, pick the first set bit in priority order, load SEL, set GNT and VALID, clear CNT, and go to GRANT.
  - Otherwise stay in IDLE with VALID = 0 and GNT = 0. SEL holds its last value.
- GRANT:
  - ACK = 1 increments CNT.
  - Release on either condition: (a) ACK = 1 and CNT+1 = MAX_BEATS; (b) REQ[SEL] = 0, sampled the same cycle.
  - On release: LAST ← SEL, VALID ← 0, GNT ← 0, go to IDLE.
  - Condition (b) with ACK = 1 in the same cycle: the beat counts as accepted and release still occurs.
- ACK while VALID = 0 is ignored; it has no effect on CNT or state.
- A REQ bit rising during GRANT has no effect until the next arbitration.
- Fairness: a continuously requesting source waits at most 3 grants.
- Reset values: state = IDLE, SEL = 2'b00, GNT = 4'b0000, VALID = 0, CNT = 0, LAST = 2'b11 (first arbitration favours index 0).

## Timing
- Arbitration latency: REQ sampled at edge n gives SEL/GNT/VALID valid after edge n.
- Release takes effect at the edge that samples the release condition; VALID is low the following cycle.
- Mandatory one-cycle IDLE gap between consecutive grants: back-to-back grants are spaced MAX_BEATS+1 cycles under continuous ACK.
- All outputs are driven from flops; there is no combinational path from REQ or ACK to any output.
- Asserting RST at any time, including mid-grant, immediately forces the reset values. The first arbitration after RST deasserts occurs at the first edge with RST low.

## Structure
- Shared package holds the state encoding (IDLE = 1'b0, GRANT = 1'b1), the default MAX_BEATS, and the SEL width constant (2).
- One sub-module: rr_pick. It is combinational, takes REQ[3:0] and LAST[1:0], and returns the winning index[1:0] plus a "found" bit. The top level instantiates it once.
- The top level holds the FSM, CNT, LAST and the output registers.

## Test plan
- Reset, then REQ = 4'b0100 held with ACK = 1 continuously → SEL = 2, GNT = 4'b0100, VALID = 1 for exactly 4 cycles. VALID then drops for 1 cycle and the same source is re-granted.
- REQ = 4'b1111 held with ACK = 1 → grant order SEL = 0, 1, 2, 3, 0. Each grant lasts 4 cycles, with a 1-cycle gap between grants.
- Grant to SEL = 1, ACK = 1 for 2 beats, then REQ[1] dropped → VALID low the next cycle. With REQ = 4'b1011 the next grant is SEL = 3.
- VALID = 0 with ACK pulsed and REQ = 0 → no state change; CNT remains 0 at the next grant.
- Assert RST mid-grant (SEL = 2, CNT = 2) → SEL = 0, GNT = 0, VALID = 0 immediately. After release with REQ = 4'b1111, the first grant is SEL = 0.
- MAX_BEATS = 1, REQ = 4'b0011, ACK toggling 1,0,1 → each grant ends on its first ACKed beat, and grants alternate SEL = 0, 1.
